// File: rtl/safe_lock_ctrl.sv
// Keypad PIN lock controller: assembles PIN entries, checks them, times the unlock window and handles re-programming.
// Define SAFE_LOCKOUT_EN to build the failed-attempt counter and the LOCKOUT state.
module safe_lock_ctrl #(
  parameter int unsigned PIN_LEN        = 4,
  parameter logic [31:0] DEFAULT_PIN    = 32'h0000_1234,
  parameter int unsigned UNLOCK_CYCLES  = 100,
  parameter int unsigned ENTRY_TIMEOUT  = 500,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  output logic       unlocked,
  output logic       err,
  output logic       pin_set,
  output logic       locked_out,
  output logic [3:0] digit_count,
  output logic [2:0] state_o
);

  localparam int unsigned BUF_W        = 4 * PIN_LEN;
  localparam logic [3:0]  CNT_FULL     = 4'(PIN_LEN);
  localparam logic [31:0] UNLOCK_LOAD  = 32'(UNLOCK_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LOAD = 32'(ENTRY_TIMEOUT - 1);
  localparam logic [3:0]  KEY_HASH     = 4'd10;
  localparam logic [3:0]  KEY_STAR     = 4'd11;
  localparam logic [3:0]  KEY_NONE     = 4'd13;

  typedef enum logic [2:0] {
    S_LOCKED  = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_SET     = 3'd4,
    S_LOCKOUT = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [BUF_W-1:0] ebuf_q, ebuf_d;
  logic [BUF_W-1:0] pin_q, pin_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             match_q, match_d;
  logic [31:0]      tmr_q, tmr_d;
  logic             unlocked_q, unlocked_d;
  logic             err_q, err_d;
  logic             pin_set_q, pin_set_d;
  logic             clear_entry;

  logic is_digit, is_hash, is_star, is_key, entry_ok, tmr_zero;

  assign is_digit = (key_code <= 4'd9);
  assign is_hash  = (key_code == KEY_HASH);
  assign is_star  = (key_code == KEY_STAR);
  assign is_key   = (key_code != KEY_NONE);
  assign entry_ok = (cnt_q == CNT_FULL) && !ovf_q;
  assign tmr_zero = (tmr_q == 32'd0);
  // Compare result is latched as ENTRY is left, so the buffer can clear on that exit.
  assign match_d  = entry_ok && (ebuf_q == pin_q);

`ifdef SAFE_LOCKOUT_EN
  localparam int unsigned      FAIL_W      = $clog2(MAX_FAILS + 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX    = FAIL_W'(MAX_FAILS);
  localparam logic [31:0]      LOCKOUT_LOAD = 32'(LOCKOUT_CYCLES - 1);

  logic [FAIL_W-1:0] fail_q, fail_d, fail_inc;
  logic              locked_out_q, locked_out_d;

  assign fail_inc = (fail_q == FAIL_MAX) ? fail_q : fail_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_q       <= '0;
      locked_out_q <= 1'b0;
    end else begin
      fail_q       <= fail_d;
      locked_out_q <= locked_out_d;
    end
  end

  assign locked_out = locked_out_q;
`else
  // Lockout tuning has no hardware in this build; the empty guard keeps the parameters referenced.
  if (MAX_FAILS == 0 || LOCKOUT_CYCLES == 0) begin : g_lockout_params_unused
  end

  assign locked_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_LOCKED;
      ebuf_q     <= '0;
      pin_q      <= DEFAULT_PIN[BUF_W-1:0];
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      match_q    <= 1'b0;
      tmr_q      <= '0;
      unlocked_q <= 1'b0;
      err_q      <= 1'b0;
      pin_set_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ebuf_q     <= ebuf_d;
      pin_q      <= pin_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      match_q    <= match_d;
      tmr_q      <= tmr_d;
      unlocked_q <= unlocked_d;
      err_q      <= err_d;
      pin_set_q  <= pin_set_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ebuf_d      = ebuf_q;
    pin_d       = pin_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    tmr_d       = tmr_q;
    clear_entry = 1'b0;
`ifdef SAFE_LOCKOUT_EN
    fail_d      = fail_q;
`endif
    case (state_q)
      S_LOCKED: begin
        if (is_digit) begin
          ebuf_d  = BUF_W'(key_code);
          cnt_d   = 4'd1;
          tmr_d   = TIMEOUT_LOAD;
          state_d = S_ENTRY;
        end
      end
      S_ENTRY, S_SET: begin
        if (is_digit) begin
          if (cnt_q == CNT_FULL) begin
            ovf_d = 1'b1;
          end else begin
            ebuf_d = (ebuf_q << 4) | BUF_W'(key_code);
            cnt_d  = cnt_q + 4'd1;
          end
        end
        if (is_key) begin
          tmr_d = TIMEOUT_LOAD;
        end else if (tmr_zero) begin
          state_d     = S_LOCKED;
          clear_entry = 1'b1;
        end else begin
          tmr_d = tmr_q - 32'd1;
        end
        if (is_star) begin
          state_d     = S_LOCKED;
          clear_entry = 1'b1;
        end else if (is_hash) begin
          clear_entry = 1'b1;
          if (state_q == S_ENTRY) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_LOCKED;
            if (entry_ok) pin_d = ebuf_q;
          end
        end
      end
      S_CHECK: begin
        if (match_q) begin
          state_d = S_OPEN;
          tmr_d   = UNLOCK_LOAD;
`ifdef SAFE_LOCKOUT_EN
          fail_d  = '0;
`endif
        end else begin
          state_d = S_LOCKED;
`ifdef SAFE_LOCKOUT_EN
          fail_d  = fail_inc;
          if (fail_inc == FAIL_MAX) begin
            state_d = S_LOCKOUT;
            tmr_d   = LOCKOUT_LOAD;
          end
`endif
        end
      end
      S_OPEN: begin
        if (is_hash) begin
          state_d = S_LOCKED;
        end else if (is_star) begin
          state_d = S_SET;
          tmr_d   = TIMEOUT_LOAD;
        end else if (tmr_zero) begin
          state_d = S_LOCKED;
        end else begin
          tmr_d = tmr_q - 32'd1;
        end
      end
`ifdef SAFE_LOCKOUT_EN
      S_LOCKOUT: begin
        if (tmr_zero) begin
          state_d = S_LOCKED;
          fail_d  = '0;
        end else begin
          tmr_d = tmr_q - 32'd1;
        end
      end
`endif
      default: state_d = S_LOCKED;
    endcase
    if (clear_entry) begin
      ebuf_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end
  end

  always_comb begin
    unlocked_d   = (state_d == S_OPEN);
    err_d        = ((state_q == S_CHECK) && !match_q) ||
                   ((state_q == S_SET) && is_hash && !entry_ok);
    pin_set_d    = (state_q == S_SET) && is_hash && entry_ok;
`ifdef SAFE_LOCKOUT_EN
    locked_out_d = (state_d == S_LOCKOUT);
`endif
  end

  assign unlocked    = unlocked_q;
  assign err         = err_q;
  assign pin_set     = pin_set_q;
  assign digit_count = cnt_q;
  assign state_o     = state_q;

endmodule
